// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, PC step,
// instruction field positions and the next-PC select code.
package ifetch_pkg;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RD_HI  = 20;
  localparam int RD_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_FLUSH
  } pc_sel_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_pc_unit.sv
// Combinational next-PC select for the fetch stage; every result is word aligned
// and all arithmetic wraps modulo 2^32.
module ifetch_pc_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  pc_sel_e     pc_sel,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_accepted,
  input  logic [31:0] branch_offset,
  input  logic [31:0] flush_addr,
  output logic [31:0] pc_next
);

  logic [31:0] pc_seq;
  logic [31:0] pc_raw;

  assign pc_seq = pc_accepted + PC_STEP;

  // NOTE: pc_raw gets a value on every path (default arm included) so this stays
  // pure combinational logic instead of inferring a latch.
  always_comb begin
    pc_raw = pc_cur;
    case (pc_sel)
      PC_HOLD:   pc_raw = pc_cur;
      PC_SEQ:    pc_raw = pc_seq;
      PC_BRANCH: pc_raw = pc_seq + branch_offset;
      PC_FLUSH:  pc_raw = flush_addr;
      default:   pc_raw = pc_cur;
    endcase
  end

  assign pc_next = align_word(pc_raw);

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, req/ack memory reads, instruction register with
// field split, valid/ready toward decode, branch and flush redirect.
// Optional build macro IFETCH_STALL_CNT_EN adds the saturating Stall_Cnt output.
module instr_fetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] PC_Out,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rd,
  output logic [4:0]  Rt,
  output logic [15:0] Imm,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Offset,
  input  logic        Flush,
  input  logic [31:0] Flush_Addr
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0] Stall_Cnt
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;
  pc_sel_e     pc_sel;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    drop_d   = drop_q;
    pc_sel   = PC_HOLD;

    case (state_q)
      FETCH: begin
        // A flush here only retargets the PC; the request goes out next cycle.
        if (Flush) begin
          pc_sel = PC_FLUSH;
        end else begin
          req_d   = 1'b1;
          addr_d  = align_word(pc_q);
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (IMem_Ack) begin
          req_d = 1'b0;
          if (Flush) begin
            pc_sel  = PC_FLUSH;
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            instr_d  = IMem_Data;
            pc_out_d = addr_q;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end else if (Flush) begin
          // The bus read cannot be cancelled, so mark its data for discard.
          pc_sel = PC_FLUSH;
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (Flush) begin
          valid_d = 1'b0;
          pc_sel  = PC_FLUSH;
          state_d = FETCH;
        end else if (valid_q && Instr_Ready) begin
          valid_d = 1'b0;
          pc_sel  = Branch_Taken ? PC_BRANCH : PC_SEQ;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  ifetch_pc_unit #(
    .PC_STEP(PC_STEP)
  ) u_pc_unit (
    .pc_sel       (pc_sel),
    .pc_cur       (pc_q),
    .pc_accepted  (pc_out_q),
    .branch_offset(Branch_Offset),
    .flush_addr   (Flush_Addr),
    .pc_next      (pc_d)
  );

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= FETCH;
      pc_q     <= align_word(PC_RESET);
      req_q    <= 1'b0;
      addr_q   <= align_word(PC_RESET);
      // NOTE: the instruction register is a plain datapath register but is still
      // reset, because decode sees its fields and they must read 0 out of reset.
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign IMem_Req    = req_q;
  assign IMem_Addr   = addr_q;
  assign Instr_Valid = valid_q;
  assign Instr       = instr_q;
  assign PC_Out      = pc_out_q;
  assign Opcode      = instr_q[OPC_HI:OPC_LO];
  assign Rs          = instr_q[RS_HI:RS_LO];
  assign Rd          = instr_q[RD_HI:RD_LO];
  assign Rt          = instr_q[RT_HI:RT_LO];
  assign Imm         = instr_q[IMM_HI:IMM_LO];

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cycle;

  always_comb begin
    stall_cycle = ((state_q == WAIT) && !IMem_Ack) ||
                  ((state_q == HOLD) && !Instr_Ready);
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: a transaction-level reference model
// checked every cycle, a field-decode vector table, directed corner sequences and
// a randomized phase.
module tb_instr_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic [31:0] PC_Out;
  logic [5:0]  Opcode;
  logic [4:0]  Rs;
  logic [4:0]  Rd;
  logic [4:0]  Rt;
  logic [15:0] Imm;
  logic        Branch_Taken;
  logic [31:0] Branch_Offset;
  logic        Flush;
  logic [31:0] Flush_Addr;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] Stall_Cnt;
  logic [15:0] stall_base;
`endif

  instr_fetch_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IMem_Req     (IMem_Req),
    .IMem_Addr    (IMem_Addr),
    .IMem_Ack     (IMem_Ack),
    .IMem_Data    (IMem_Data),
    .Instr_Valid  (Instr_Valid),
    .Instr_Ready  (Instr_Ready),
    .Instr        (Instr),
    .PC_Out       (PC_Out),
    .Opcode       (Opcode),
    .Rs           (Rs),
    .Rd           (Rd),
    .Rt           (Rt),
    .Imm          (Imm),
    .Branch_Taken (Branch_Taken),
    .Branch_Offset(Branch_Offset),
    .Flush        (Flush),
    .Flush_Addr   (Flush_Addr)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .Stall_Cnt    (Stall_Cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a fetch engine that is either idle, has one read in flight
  // (possibly to be discarded), or is presenting one instruction to decode.
  logic [31:0] m_pc, m_addr, m_instr, m_pc_out;
  bit          m_req, m_valid, m_drop;
  int unsigned m_stall;

  // Memory responder controls.
  bit          rand_mode = 1'b0;
  int          ack_wait  = 0;
  int          req_age   = 0;
  logic [31:0] data_q[$];

  typedef struct {
    logic [31:0] data;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_step();
    if (!Reset) begin
      m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0;
      m_req = 1'b0; m_valid = 1'b0; m_drop = 1'b0; m_stall = 0;
      return;
    end
    if ((m_req && !IMem_Ack) || (m_valid && !Instr_Ready)) begin
      if (m_stall < 65535) m_stall++;
    end
    if (m_valid) begin
      if (Flush) begin
        m_valid = 1'b0;
        m_pc    = al(Flush_Addr);
      end else if (Instr_Ready) begin
        m_valid = 1'b0;
        m_pc    = al(m_pc_out + 32'd4 + (Branch_Taken ? Branch_Offset : 32'd0));
      end
    end else if (m_req) begin
      if (IMem_Ack) begin
        m_req = 1'b0;
        if (Flush) begin
          m_drop = 1'b0;
          m_pc   = al(Flush_Addr);
        end else if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          m_valid  = 1'b1;
          m_instr  = IMem_Data;
          m_pc_out = m_addr;
        end
      end else if (Flush) begin
        m_drop = 1'b1;
        m_pc   = al(Flush_Addr);
      end
    end else begin
      if (Flush) m_pc = al(Flush_Addr);
      else begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic compare_all();
    check("req", IMem_Req, m_req);
    if (m_req) check("addr", IMem_Addr, m_addr);
    check("valid", Instr_Valid, m_valid);
    check("instr", Instr, m_instr);
    check("pc_out", PC_Out, m_pc_out);
    check("opcode", Opcode, m_instr >> 26);
    check("rs", Rs, (m_instr >> 21) & 32'h1F);
    check("rd", Rd, (m_instr >> 16) & 32'h1F);
    check("rt", Rt, (m_instr >> 11) & 32'h1F);
    check("imm", Imm, m_instr & 32'hFFFF);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cnt", Stall_Cnt, m_stall);
`endif
  endtask

  // One clock: model consumes the inputs held across the edge, outputs are
  // compared 1ns later, then the memory responder drives the next cycle's ack.
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
    if (IMem_Req) begin
      if (rand_mode) IMem_Ack = ($urandom_range(0, 2) == 0);
      else           IMem_Ack = (req_age >= ack_wait);
      if (IMem_Ack) begin
        req_age = 0;
        if (data_q.size() > 0) IMem_Data = data_q.pop_front();
        else                   IMem_Data = mem_word(IMem_Addr);
      end else begin
        req_age++;
        IMem_Data = $urandom;
      end
    end else begin
      IMem_Ack  = 1'b0;
      req_age   = 0;
      IMem_Data = $urandom;
    end
  endtask

  task automatic do_reset();
    Reset        = 1'b0;
    Flush        = 1'b0;
    Branch_Taken = 1'b0;
    Instr_Ready  = 1'b1;
    rand_mode    = 1'b0;
    ack_wait     = 0;
    data_q.delete();
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !Instr_Valid; i++) tick();
    check(name, Instr_Valid, 1'b1);
  endtask

  task automatic wait_req(input string name, input int budget);
    for (int i = 0; i < budget && !IMem_Req; i++) tick();
    check(name, IMem_Req, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_instr, held_pc;
    bit          seen_idle;

    Reset = 1'b0; IMem_Ack = 1'b0; IMem_Data = 32'h0; Instr_Ready = 1'b1;
    Branch_Taken = 1'b0; Branch_Offset = 32'h0; Flush = 1'b0; Flush_Addr = 32'h0;

    vecs[0] = '{32'hC000_FFFE, 6'h30, 5'h00, 5'h00, 5'h1F, 16'hFFFE};
    vecs[1] = '{32'hFFFF_FFFF, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF};
    vecs[2] = '{32'h0000_0000, 6'h00, 5'h00, 5'h00, 5'h00, 16'h0000};
    vecs[3] = '{32'h8C22_0004, 6'h23, 5'h01, 5'h02, 5'h00, 16'h0004};
    vecs[4] = '{32'h0421_F800, 6'h01, 5'h01, 5'h01, 5'h1F, 16'hF800};

    // Reset state.
    do_reset();
    check("rst_req", IMem_Req, 1'b0);
    check("rst_valid", Instr_Valid, 1'b0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc_out", PC_Out, 32'h0);
    check("rst_opcode", Opcode, 6'h0);

    // Zero-wait memory, decode always ready: one instruction every 3 cycles.
    data_q.push_back(32'hC000_FFFE);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("seq_req", IMem_Req, (k % 3) == 1);
      check("seq_valid", Instr_Valid, (k % 3) == 2);
      if ((k % 3) == 1) check("seq_addr", IMem_Addr, 32'(4 * (k / 3)));
      if (k == 2) begin
        check("seq_opcode", Opcode, 6'b110000);
        check("seq_imm", Imm, 16'hFFFE);
        check("seq_pc_out", PC_Out, 32'h0);
      end
    end

    // Field split vectors.
    for (int v = 0; v < 5; v++) begin
      data_q.push_back(vecs[v].data);
      wait_valid("vec_valid", 10);
      check("vec_instr", Instr, vecs[v].data);
      check("vec_opcode", Opcode, vecs[v].opc);
      check("vec_rs", Rs, vecs[v].rs);
      check("vec_rd", Rd, vecs[v].rd);
      check("vec_rt", Rt, vecs[v].rt);
      check("vec_imm", Imm, vecs[v].imm);
      tick();
    end

    // Decode back-pressure for 5 cycles.
    wait_valid("stall_valid", 10);
    Instr_Ready = 1'b0;
    held_instr  = Instr;
    held_pc     = PC_Out;
`ifdef IFETCH_STALL_CNT_EN
    stall_base  = Stall_Cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", Instr, held_instr);
      check("stall_pc_out", PC_Out, held_pc);
      check("stall_no_req", IMem_Req, 1'b0);
      check("stall_valid_hi", Instr_Valid, 1'b1);
    end
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cnt_delta", Stall_Cnt - stall_base, 16'd5);
`endif
    Instr_Ready = 1'b1;
    tick();

    // Taken branch accepted at PC_Out=0x10 with offset -8.
    do_reset();
    for (int i = 0; i < 40 && !(Instr_Valid && PC_Out == 32'h10); i++) tick();
    check("br_at_0x10", PC_Out, 32'h10);
    Branch_Taken  = 1'b1;
    Branch_Offset = 32'hFFFF_FFF8;
    tick();
    Branch_Taken  = 1'b0;
    wait_req("br_req", 10);
    check("br_target", IMem_Addr, 32'h0C);
    // Branch_Taken held outside the accept cycle must be ignored.
    Branch_Taken  = 1'b1;
    Branch_Offset = 32'h0000_1000;
    Instr_Ready   = 1'b0;
    wait_valid("br_hold_valid", 10);
    tick();
    tick();
    Branch_Taken = 1'b0;
    Instr_Ready  = 1'b1;
    tick();
    wait_req("br_seq_req", 10);
    check("br_ignored_addr", IMem_Addr, 32'h10);

    // Flush while a read is outstanding and the ack is 3 cycles late.
    do_reset();
    ack_wait = 3;
    wait_req("fl_req", 10);
    Flush      = 1'b1;
    Flush_Addr = 32'h100;
    tick();
    Flush     = 1'b0;
    seen_idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("fl_no_valid", Instr_Valid, 1'b0);
      if (!IMem_Req) seen_idle = 1'b1;
      else if (seen_idle) break;
    end
    check("fl_new_req", IMem_Req, 1'b1);
    check("fl_new_addr", IMem_Addr, 32'h100);
    ack_wait = 0;

    // Flush from HOLD to the last word, then wrap sequentially to 0.
    wait_valid("wr_valid0", 20);
    Flush      = 1'b1;
    Flush_Addr = 32'hFFFF_FFFC;
    tick();
    Flush = 1'b0;
    wait_req("wr_req", 10);
    check("wr_addr_top", IMem_Addr, 32'hFFFF_FFFC);
    wait_valid("wr_valid", 10);
    check("wr_pc_out", PC_Out, 32'hFFFF_FFFC);
    tick();
    wait_req("wr_req2", 10);
    check("wr_addr_wrap", IMem_Addr, 32'h0);

    // Reset asserted while holding an instruction.
    do_reset();
    wait_valid("rh_valid0", 10);
    tick();
    wait_valid("rh_valid1", 10);
    Instr_Ready = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check("rh_valid", Instr_Valid, 1'b0);
    check("rh_req", IMem_Req, 1'b0);
    check("rh_instr", Instr, 32'h0);
    Reset       = 1'b1;
    Instr_Ready = 1'b1;
    tick();
    check("rh_req_after", IMem_Req, 1'b1);
    check("rh_addr_after", IMem_Addr, 32'h0);

    // Reset asserted while a read is outstanding.
    wait_valid("rw_valid0", 10);
    ack_wait = 5;
    wait_req("rw_req", 10);
    check("rw_addr", IMem_Addr, 32'h4);
    tick();
    Reset = 1'b0;
    tick();
    check("rw_valid", Instr_Valid, 1'b0);
    check("rw_req", IMem_Req, 1'b0);
    Reset    = 1'b1;
    ack_wait = 0;
    tick();
    check("rw_req_after", IMem_Req, 1'b1);
    check("rw_addr_after", IMem_Addr, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r             = $urandom;
      Instr_Ready   = ($urandom_range(0, 3) != 0);
      Branch_Taken  = $urandom_range(0, 1) == 1;
      Branch_Offset = {{14{r[15]}}, r[15:0], 2'b00};
      Flush         = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) Flush_Addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           Flush_Addr = $urandom;
      Reset         = ($urandom_range(0, 199) != 0);
      tick();
    end
    Reset = 1'b1;
    Flush = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
